// File: rtl/lvds_tx_framer.sv
// TX framer for the 8-bit LVDS link: sends the training pattern until the far end locks, then payload.
// data_out lags word selection by two edges; tx_ready is high in every DATA cycle, regardless of tx_valid.
module lvds_tx_framer #(
   parameter int          TRAIN_LEN    = 64,
   parameter int          LOCK_TIMEOUT = 1024,
   parameter int          MAX_RETRY    = 4,
   parameter logic [7:0]  IDLE_CODE    = 8'hBC
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       lock_in,
   input  logic [7:0] pattern,
   input  logic [2:0] slip,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] data_out,
   output logic       training,
   output logic       linked,
   output logic       fail
);

   localparam int CNT_MAX = (TRAIN_LEN > LOCK_TIMEOUT) ? TRAIN_LEN : LOCK_TIMEOUT;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int RET_W   = $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_LEN - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [RET_W-1:0] RETRY_LIM  = RET_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRAIN,
      ST_WAIT,
      ST_DATA,
      ST_FAIL
   } state_t;

   logic [1:0]       rst_sync_q;
   logic             rst_int;
   logic [1:0]       start_sync_q;
   logic [1:0]       lock_sync_q;
   logic             start_s;
   logic             lock_s;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [RET_W-1:0] retry_q;
   logic [RET_W-1:0] retry_d;
   logic [2:0]       slip_q;

   logic [7:0]       word_d;
   logic [7:0]       word_q;
   logic [7:0]       prev_q;
   logic [15:0]      pair;
   logic [7:0]       data_out_q;

   // Assert immediately, release on the second edge after rst falls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_sync_q <= 2'b11;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b0};
      end
   end

   assign rst_int = rst_sync_q[1];

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         start_sync_q <= 2'b00;
         lock_sync_q  <= 2'b00;
      end else begin
         start_sync_q <= {start_sync_q[0], start};
         lock_sync_q  <= {lock_sync_q[0], lock_in};
      end
   end

   assign start_s = start_sync_q[1];
   assign lock_s  = lock_sync_q[1];

   assign retry_d = retry_q + 1'b1;

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         retry_q <= '0;
         slip_q  <= 3'd0;
      end else if (!start_s) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_TRAIN;
               slip_q  <= slip;
               cnt_q   <= '0;
               retry_q <= '0;
            end
            ST_TRAIN: begin
               if (cnt_q == TRAIN_LAST) begin
                  state_q <= ST_WAIT;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_WAIT: begin
               // Lock arriving on the timeout cycle wins; no retry is charged.
               if (lock_s) begin
                  state_q <= ST_DATA;
                  cnt_q   <= '0;
               end else if (cnt_q == LOCK_LAST) begin
                  retry_q <= retry_d;
                  cnt_q   <= '0;
                  state_q <= (retry_d == RETRY_LIM) ? ST_FAIL : ST_TRAIN;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DATA: begin
               if (!lock_s) begin
                  state_q <= ST_TRAIN;
                  cnt_q   <= '0;
                  retry_q <= '0;
               end
            end
            ST_FAIL: begin
               state_q <= ST_FAIL;
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      word_d = 8'h00;
      case (state_q)
         ST_TRAIN, ST_WAIT: word_d = pattern;
         ST_DATA:           word_d = tx_valid ? tx_data : IDLE_CODE;
         default:           word_d = 8'h00;
      endcase
   end

   assign pair = {word_q, prev_q};

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         word_q     <= 8'h00;
         prev_q     <= 8'h00;
         data_out_q <= 8'h00;
      end else begin
         word_q     <= word_d;
         prev_q     <= word_q;
         data_out_q <= pair[4'd15 - {1'b0, slip_q} -: 8];
      end
   end

   assign data_out = data_out_q;
   assign tx_ready = (state_q == ST_DATA);
   assign training = (state_q == ST_TRAIN) || (state_q == ST_WAIT);
   assign linked   = (state_q == ST_DATA);
   assign fail     = (state_q == ST_FAIL);

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Bench for lvds_tx_framer: per-cycle reference model feeds an expectation queue drained by a monitor.
module tb_lvds_tx_framer;

   localparam int TL = 64;
   localparam int LT = 1024;
   localparam int MR = 4;

   localparam int M_OFF   = 0;
   localparam int M_TRAIN = 1;
   localparam int M_WAIT  = 2;
   localparam int M_LINK  = 3;
   localparam int M_DEAD  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       lock_in;
   logic [7:0] pattern;
   logic [2:0] slip;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] data_out;
   logic       training;
   logic       linked;
   logic       fail;

   lvds_tx_framer dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .lock_in  (lock_in),
      .pattern  (pattern),
      .slip     (slip),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .data_out (data_out),
      .training (training),
      .linked   (linked),
      .fail     (fail)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       rdy;
      logic       trn;
      logic       lnk;
      logic       fl;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   logic       c_rst, c_start, c_lock, c_valid;
   logic [7:0] c_pattern, c_data;
   logic [2:0] c_slip;

   always @(posedge clk) begin
      c_rst     = rst;
      c_start   = start;
      c_lock    = lock_in;
      c_valid   = tx_valid;
      c_pattern = pattern;
      c_data    = tx_data;
      c_slip    = slip;
   end

   int         mode, elapsed, attempts, since, slip_m;
   bit         in_rst, ss1, ss2, ls1, ls2;
   logic [7:0] w1, w2, dout_m;

   task automatic reset_model();
      mode = M_OFF; elapsed = 0; attempts = 0; since = 0; slip_m = 0;
      in_rst = 1'b1; ss1 = 0; ss2 = 0; ls1 = 0; ls2 = 0;
      w1 = 8'h00; w2 = 8'h00; dout_m = 8'h00;
   endtask

   task automatic edge_step();
      logic [7:0]  w;
      logic [15:0] two;
      case (mode)
         M_TRAIN, M_WAIT: w = c_pattern;
         M_LINK:          w = c_valid ? c_data : 8'hBC;
         default:         w = 8'h00;
      endcase
      two    = {w1, w2};
      dout_m = 8'(two >> (8 - slip_m));
      w2 = w1;
      w1 = w;
      if (!ss2) begin
         mode = M_OFF;
      end else if (mode == M_OFF) begin
         mode = M_TRAIN; slip_m = int'(c_slip); elapsed = 0; attempts = 0;
      end else if (mode == M_TRAIN) begin
         elapsed++;
         if (elapsed == TL) begin mode = M_WAIT; elapsed = 0; end
      end else if (mode == M_WAIT) begin
         if (ls2) begin
            mode = M_LINK;
         end else begin
            elapsed++;
            if (elapsed == LT) begin
               attempts++;
               elapsed = 0;
               mode = (attempts == MR) ? M_DEAD : M_TRAIN;
            end
         end
      end else if (mode == M_LINK) begin
         if (!ls2) begin mode = M_TRAIN; elapsed = 0; attempts = 0; end
      end
      ss2 = ss1; ss1 = c_start;
      ls2 = ls1; ls1 = c_lock;
   endtask

   initial reset_model();

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         reset_model();
      end else if (c_rst) begin
         since = 0;
      end else if (in_rst) begin
         since++;
         if (since >= 2) in_rst = 1'b0;
      end else begin
         edge_step();
      end
      e.d   = dout_m;
      e.rdy = (mode == M_LINK);
      e.trn = (mode == M_TRAIN) || (mode == M_WAIT);
      e.lnk = (mode == M_LINK);
      e.fl  = (mode == M_DEAD);
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if ({data_out, tx_ready, training, linked, fail} !== e) begin
            n_bad++;
            $display("FAIL outputs cyc %0d: got data_out=%h rdy=%b trn=%b lnk=%b fail=%b, want data_out=%h rdy=%b trn=%b lnk=%b fail=%b",
                     cyc, data_out, tx_ready, training, linked, fail, e.d, e.rdy, e.trn, e.lnk, e.fl);
         end
      end
   end

   task automatic check_point(input string what, input logic [7:0] want_d, input logic want_rdy,
                              input logic want_trn, input logic want_lnk, input logic want_fl);
      n_cmp++;
      if ({data_out, tx_ready, training, linked, fail} !== {want_d, want_rdy, want_trn, want_lnk, want_fl}) begin
         n_bad++;
         $display("FAIL %s: got data_out=%h rdy=%b trn=%b lnk=%b fail=%b, want data_out=%h rdy=%b trn=%b lnk=%b fail=%b",
                  what, data_out, tx_ready, training, linked, fail, want_d, want_rdy, want_trn, want_lnk, want_fl);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic rand_tx();
      tx_valid = 1'($urandom);
      tx_data  = 8'($urandom);
   endtask

   task automatic run_rand(input int n);
      for (int i = 0; i < n; i++) begin
         rand_tx();
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; lock_in = 1'b1; pattern = 8'hA5; slip = 3'd0;
      tx_valid = 1'b0; tx_data = 8'h00;
      repeat (5) tick();
      check_point("reset state", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      repeat (80) tick();
      n_cmp++;
      if (!(linked === 1'b1 && tx_ready === 1'b1 && training === 1'b0)) begin
         n_bad++;
         $display("FAIL link after training: lnk=%b rdy=%b trn=%b", linked, tx_ready, training);
      end

      for (int i = 1; i <= 16; i++) begin
         tx_valid = 1'b1; tx_data = 8'(i);
         tick();
         tx_valid = 1'b0; tx_data = 8'($urandom);
         tick();
      end

      for (int i = 0; i < 100; i++) begin
         slip = 3'($urandom);
         rand_tx();
         tick();
      end

      lock_in = 1'b0;
      run_rand(10);
      lock_in = 1'b1;
      run_rand(80);
      start = 1'b0;
      run_rand(8);

      for (int t = 0; t < 4; t++) begin
         slip    = (t == 0) ? 3'd3 : 3'($urandom_range(0, 7));
         pattern = (t == 0) ? 8'hA5 : 8'($urandom);
         start   = 1'b1;
         lock_in = 1'b1;
         run_rand(115);
         start = 1'b0;
         run_rand(6);
      end

      pattern = 8'($urandom); slip = 3'd0; start = 1'b1;
      for (int i = 0; i < 600; i++) begin
         lock_in = ($urandom_range(0, 39) == 0);
         rand_tx();
         tick();
      end
      start = 1'b0;
      run_rand(6);

      lock_in = 1'b0; pattern = 8'h3C; start = 1'b1;
      run_rand(MR * (TL + LT) + 20);
      check_point("expired wait", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      start = 1'b0;
      run_rand(8);
      check_point("stop from fail", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

      start = 1'b1; lock_in = 1'b1;
      run_rand(75);
      tx_valid = 1'b1; tx_data = 8'h5A;
      tick();
      rst = 1'b1;
      run_rand(3);
      check_point("mid-stream reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      run_rand(80);
      start = 1'b0;
      run_rand(6);

      @(negedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
